rtc_wr_scheduler: RTL
=====================

Name: rtc_wr_scheduler

Overview:
Arbitrates three requesters of the RTC register-write engine and sequences their transactions. The requesters are: a time/date set (6 bytes, addresses 0x21..0x26), a timer set (3 bytes, 0x41..0x43) and a single generic register write. For each byte it drives the engine's start/address/data, waits for the engine's completion pulse, then inserts a low gap. It sits between the user-control FSM and the write engine.

Parameters:
GAP_CYCLES, 2, cycles wr_iniciar is held low between consecutive bytes (min 2)
TIMEOUT, 1023, max cycles waiting for wr_final before abort (10-bit counter)
HORA_BASE, 8'h21, first address of time/date burst
TIMER_BASE, 8'h41, first address of timer burst

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_hora  in  1  time/date set request, level, held until ack_hora
hora_data  in  48  {anio,mes,dia,hora,min,seg}; seg in [7:0]
req_timer  in  1  timer set request, level
timer_data  in  24  {t2,t1,t0}; t0 in [7:0]
req_single  in  1  single write request, level
single_dir  in  8  single write address
single_dato  in  8  single write data
ack_hora / ack_timer / ack_single  out  1 each  one-cycle completion pulse
error  out  1  one-cycle pulse with the ack when the transaction timed out
busy  out  1  high from grant until ack cycle inclusive
wr_iniciar  out  1  engine start, held high for whole byte transaction
wr_dir  out  8  engine address
wr_dato  out  8  engine data
wr_final  in  1  engine completion pulse

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: all outputs 0. State IDLE. RR pointer = hora, so priority after reset is timer > single > hora.
- States: IDLE, GRANT, ISSUE, WAIT, GAP, DONE.
- IDLE: if any req is high, select the winner round-robin, starting after the last granted requester. Go to GRANT.
- GRANT (1 cycle): latch the winner's payload into an internal 48-bit shift buffer. Set count = 6/3/1 and base address (HORA_BASE/TIMER_BASE/single_dir). Set busy=1. Update the RR pointer to the winner. Later requester input changes are ignored.
- ISSUE: wr_dir = base+index, wr_dato = buffer[7:0], wr_iniciar = 1. Clear the timeout counter. Go to WAIT.
- WAIT: hold wr_iniciar/dir/dato stable and count cycles.
  - wr_final=1 → wr_iniciar=0 on the next edge; decrement count; shift buffer right 8; go to GAP.
  - Counter reaches TIMEOUT with no wr_final → wr_iniciar=0, set error flag, go to DONE and skip the remaining bytes.
- GAP: wr_iniciar low for GAP_CYCLES cycles. Then ISSUE if count≠0, else DONE. This guarantees the engine is held in its idle/reset condition between bytes.
- DONE (1 cycle): pulse the winner's ack. error=1 the same cycle if flagged. busy=0 next cycle. Return to IDLE.
- Minimum latency, single write: req→ack = 3 + engine time + GAP_CYCLES + 1 cycles.
- Address arithmetic: 8-bit, wraps modulo 256; single writes use index 0 only.
- wr_final outside WAIT is ignored.
- A requester that drops req before ack is still completed; its ack pulse is still issued.
- A requester whose req is still high in the cycle after ack is treated as a new request.
- Simultaneous requests are resolved purely by the RR pointer. No starvation: any pending requester is served within 2 other transactions.
- Reset mid-transaction: immediate return to IDLE; wr_iniciar=0 next edge; no ack or error pulse.

Decomposition:
- Shared package rtc_pkg: HORA_BASE, TIMER_BASE, state encoding, requester ids (REQ_HORA=0, REQ_TIMER=1, REQ_SINGLE=2).
- One sub-module rr_arbiter3 (3-way round-robin grant, combinational select plus pointer register).

Test Plan:
- Single: req_single, dir=8'h10, dato=8'h55; engine model pulses wr_final 5 cycles after start → one transaction (dir 10/dato 55), wr_iniciar low ≥2 cycles, ack_single once, error=0.
- Hora burst: hora_data=48'h16_09_0A_14_1E_2D → six transactions in order: (21,2D)(22,1E)(23,14)(24,0A)(25,09)(26,16), with wr_iniciar low ≥GAP_CYCLES between each; a single ack_hora.
- Contention: all three req high from reset → service order timer, single, hora. Re-raise timer during hora → next grant after hora is timer.
- Timeout: engine never pulses wr_final on timer burst → wr_iniciar drops after 1023 WAIT cycles, ack_timer and error pulse together, remaining 2 bytes not issued.
- Reset mid-burst: reset during the 3rd hora byte in WAIT → next cycle all outputs 0, no ack; a new req_single afterwards completes normally.
- Late wr_final: wr_final pulsed in GAP/IDLE → no effect on count, outputs or acks.

Source files
------------

// File: rtl/rtc_pkg.sv
`default_nettype none
// ==================================================================
// rtc_pkg : shared constants, requester ids and FSM states for the
//           RTC register-write scheduler.   Revision: 1.0
// ==================================================================
package rtc_pkg;

   localparam logic [7:0] HORA_BASE  = 8'h21;
   localparam logic [7:0] TIMER_BASE = 8'h41;

   typedef enum logic [1:0] {
      REQ_HORA   = 2'd0,
      REQ_TIMER  = 2'd1,
      REQ_SINGLE = 2'd2
   } req_id_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Round-robin successor: hora -> timer -> single -> hora.
   function automatic req_id_t rr_next(input req_id_t id);
      case (id)
         REQ_HORA:  rr_next = REQ_TIMER;
         REQ_TIMER: rr_next = REQ_SINGLE;
         default:   rr_next = REQ_HORA;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ==================================================================
// rr_arbiter3 : 3-way round-robin select with last-grant pointer.
//               Revision: 1.0
// ==================================================================
module rr_arbiter3 (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req,
   input  logic             update,
   input  rtc_pkg::req_id_t update_id,
   output logic             grant_valid,
   output rtc_pkg::req_id_t grant_id
);
   import rtc_pkg::*;

   req_id_t last;
   req_id_t cand1;
   req_id_t cand2;

   assign cand1 = rr_next(last);
   assign cand2 = rr_next(cand1);

   // The last winner has the lowest priority on the next round.
   always_comb begin
      grant_valid = |req;
      grant_id    = last;
      if (req[cand1]) begin
         grant_id = cand1;
      end else if (req[cand2]) begin
         grant_id = cand2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last <= REQ_HORA;
      end else if (update) begin
         last <= update_id;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rtc_wr_scheduler.sv
`default_nettype none
// ==================================================================
// rtc_wr_scheduler : arbitrates time/date, timer and single writes and
//                    sequences them byte by byte into the write engine.
//                    Revision: 1.0
// ==================================================================
module rtc_wr_scheduler #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1023,
   parameter logic [7:0]  HORA_BASE  = rtc_pkg::HORA_BASE,
   parameter logic [7:0]  TIMER_BASE = rtc_pkg::TIMER_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_hora,
   input  logic [47:0] hora_data,
   input  logic        req_timer,
   input  logic [23:0] timer_data,
   input  logic        req_single,
   input  logic [7:0]  single_dir,
   input  logic [7:0]  single_dato,
   output logic        ack_hora,
   output logic        ack_timer,
   output logic        ack_single,
   output logic        error,
   output logic        busy,
   output logic        wr_iniciar,
   output logic [7:0]  wr_dir,
   output logic [7:0]  wr_dato,
   input  logic        wr_final
);
   import rtc_pkg::*;

   localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);
   localparam logic [9:0] GAP_LAST     = 10'(GAP_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   req_id_t     winner;
   req_id_t     sel_id;
   logic        sel_valid;
   logic        grant_update;
   logic [47:0] shift_buf;
   logic [2:0]  byte_cnt;
   logic [2:0]  byte_idx;
   logic [7:0]  base_addr;
   logic [9:0]  cycle_cnt;

   assign grant_update = (state == ST_GRANT);

   rr_arbiter3 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         ({req_single, req_timer, req_hora}),
      .update      (grant_update),
      .update_id   (winner),
      .grant_valid (sel_valid),
      .grant_id    (sel_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (sel_valid) next_state = ST_GRANT;
         ST_GRANT: next_state = ST_ISSUE;
         ST_ISSUE: next_state = ST_WAIT;
         ST_WAIT: begin
            // A completion in the last allowed cycle still counts as success.
            if (wr_final) begin
               next_state = ST_GAP;
            end else if (cycle_cnt == TIMEOUT_LAST) begin
               next_state = ST_DONE;
            end
         end
         ST_GAP: begin
            if (cycle_cnt == GAP_LAST) begin
               next_state = (byte_cnt == 3'd0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         winner    <= REQ_HORA;
         shift_buf <= '0;
         byte_cnt  <= '0;
         byte_idx  <= '0;
         base_addr <= '0;
         cycle_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: if (sel_valid) winner <= sel_id;
            ST_GRANT: begin
               byte_idx <= '0;
               case (winner)
                  REQ_HORA: begin
                     shift_buf <= hora_data;
                     byte_cnt  <= 3'd6;
                     base_addr <= HORA_BASE;
                  end
                  REQ_TIMER: begin
                     shift_buf <= {24'h0, timer_data};
                     byte_cnt  <= 3'd3;
                     base_addr <= TIMER_BASE;
                  end
                  default: begin
                     shift_buf <= {40'h0, single_dato};
                     byte_cnt  <= 3'd1;
                     base_addr <= single_dir;
                  end
               endcase
            end
            ST_ISSUE: cycle_cnt <= '0;
            ST_WAIT: begin
               if (wr_final) begin
                  shift_buf <= {8'h00, shift_buf[47:8]};
                  byte_cnt  <= byte_cnt - 3'd1;
                  byte_idx  <= byte_idx + 3'd1;
                  cycle_cnt <= '0;
               end else begin
                  cycle_cnt <= cycle_cnt + 10'd1;
               end
            end
            ST_GAP:  cycle_cnt <= cycle_cnt + 10'd1;
            default: ;
         endcase
      end
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= 1'b0;
         wr_iniciar <= 1'b0;
         wr_dir     <= '0;
         wr_dato    <= '0;
         ack_hora   <= 1'b0;
         ack_timer  <= 1'b0;
         ack_single <= 1'b0;
         error      <= 1'b0;
      end else begin
         busy       <= (next_state != ST_IDLE);
         wr_iniciar <= (next_state == ST_WAIT);
         if (state == ST_ISSUE) begin
            wr_dir  <= base_addr + {5'd0, byte_idx};
            wr_dato <= shift_buf[7:0];
         end
         ack_hora   <= (next_state == ST_DONE) && (winner == REQ_HORA);
         ack_timer  <= (next_state == ST_DONE) && (winner == REQ_TIMER);
         ack_single <= (next_state == ST_DONE) && (winner == REQ_SINGLE);
         error      <= (state == ST_WAIT) && (next_state == ST_DONE);
      end
   end

endmodule
`default_nettype wire
